minibus_ram_slave: RTL

Minibus slave memory that terminates requests issued by the memory controller's minibus master port. Holds a word-organised RAM, accepts one byte/half/word read or write at a time, applies a configurable wait latency, and returns a single-cycle `ack` with right-justified read data. Serves as the backing store for both instruction fetch and data access in single-port system builds.

---
 rtl/rv32ima_pkg.sv | 42 ++++
 rtl/minibus_ram_array.sv | 27 ++
 rtl/minibus_ram_slave.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rv32ima_pkg.sv
// Shared rv32ima types: minibus request/response bundles, width codes,
// RAM slave FSM states and a byte-lane enable helper.
package rv32ima_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        wen;
    logic        ren;
  } minibus_req_pack;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
  } minibus_res_pack;

  localparam logic [1:0] MINIBUS_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MINIBUS_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MINIBUS_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } minibus_ram_state_e;

  function automatic logic [3:0] minibus_lane_be(
    input logic [1:0] width,
    input logic [1:0] a
  );
    logic [3:0] be;
    unique case (1'b1)
      (width == MINIBUS_WIDTH_BYTE): be = 4'b0001 << a;
      (width == MINIBUS_WIDTH_HALF): be = a[1] ? 4'b1100 : 4'b0011;
      (width == MINIBUS_WIDTH_WORD): be = 4'b1111;
      default:                       be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/minibus_ram_array.sv
// Single-port word RAM: byte-enable synchronous write, registered read.
// Ports: clk, idx (word index), we, be[3:0], wdata[31:0], rdata[31:0].
module minibus_ram_array #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/minibus_ram_slave.sv
// Minibus RAM slave: one byte/half/word access at a time, LATENCY wait
// cycles, single-cycle ack with right-justified zero-extended rdata.
// Ports: clk, rst (sync, active-high), req, res {ack,rdata}, err.
// Option: MINIBUS_RAM_ALIGN_CHECK_EN makes misaligned half/word a fault;
// without it the low address bits are aligned down per width.
module minibus_ram_slave
  import rv32ima_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  minibus_req_pack req,
  output minibus_res_pack res,
  output logic            err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LM1 = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam int CW  = (LM1 > 0) ? $clog2(LM1 + 1) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  minibus_ram_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  width_q;
  logic        wr_q;

  logic        range_flt;
  logic        width_flt;
  logic        align_flt;
  logic        fault;
  logic [1:0]  lo;

  logic [AW-1:0] idx;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic [31:0]   word;
  logic [31:0]   sh;
  logic [31:0]   lane;
  logic          ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.wen | req.ren) begin
          cap     = 1'b1;
          cnt_d   = CW'(LM1);
          state_d = (LATENCY > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        addr_q  <= req.addr;
        wdata_q <= req.wdata;
        width_q <= req.width;
        // wen wins when both strobes are set
        wr_q    <= req.wen;
      end
    end
  end

  always_comb begin
    range_flt = {1'b0, addr_q} >= LIMIT;
    width_flt = width_q == 2'b11;
    align_flt = 1'b0;
    lo        = addr_q[1:0];
`ifdef MINIBUS_RAM_ALIGN_CHECK_EN
    unique case (1'b1)
      (width_q == MINIBUS_WIDTH_HALF): align_flt = addr_q[0];
      (width_q == MINIBUS_WIDTH_WORD): align_flt = |addr_q[1:0];
      default:                         align_flt = 1'b0;
    endcase
`else
    unique case (1'b1)
      (width_q == MINIBUS_WIDTH_HALF): lo = {addr_q[1], 1'b0};
      (width_q == MINIBUS_WIDTH_WORD): lo = 2'b00;
      default:                         lo = addr_q[1:0];
    endcase
`endif
    fault = range_flt | width_flt | align_flt;
  end

  // In IDLE the array reads at the incoming index so data is ready
  // for a zero-latency ack; afterwards it tracks the latched index.
  assign idx = (state_q == IDLE) ? req.addr[AW+1:2]
                                 : addr_q[AW+1:2];

  assign ack = state_q == ACK;
  assign we  = ack & wr_q & ~fault;
  assign be  = minibus_lane_be(width_q, lo);

  always_comb begin
    unique case (1'b1)
      (width_q == MINIBUS_WIDTH_BYTE): wdat = {4{wdata_q[7:0]}};
      (width_q == MINIBUS_WIDTH_HALF): wdat = {2{wdata_q[15:0]}};
      default:                         wdat = wdata_q;
    endcase
  end

  minibus_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .idx   (idx),
    .we    (we),
    .be    (be),
    .wdata (wdat),
    .rdata (word)
  );

  assign sh = word >> {lo, 3'b000};

  always_comb begin
    unique case (1'b1)
      (width_q == MINIBUS_WIDTH_BYTE): lane = {24'b0, sh[7:0]};
      (width_q == MINIBUS_WIDTH_HALF): lane = {16'b0, sh[15:0]};
      (width_q == MINIBUS_WIDTH_WORD): lane = sh;
      default:                         lane = '0;
    endcase
  end

  assign res.ack   = ack;
  assign res.rdata = (ack & ~fault) ? lane : '0;
  assign err       = ack & fault;

endmodule
